// File: rtl/cube_pkg.sv
// Shared types and helpers for the isometric cube face rasteriser.
//   top_state_t    : per-cube colour state shown on the top face
//   occ_state_t    : whether Q*bert currently stands on the top face
//   XW/YW/DW/PW    : screen coordinate, signed delta and product widths
//   sext_d         : sign-extends a delta to product width
//   colour_advance : next colour state after a landing
package cube_pkg;

    localparam int XW = 11;
    localparam int YW = 10;
    localparam int DW = 13;
    localparam int PW = 24;

    typedef enum logic [1:0] {
        UNVISITED = 2'd0,
        INTER     = 2'd1,
        DONE      = 2'd2
    } top_state_t;

    typedef enum logic {
        OFF = 1'b0,
        ON  = 1'b1
    } occ_state_t;

    function automatic logic signed [PW-1:0] sext_d(input logic signed [DW-1:0] v);
        return {{(PW-DW){v[DW-1]}}, v};
    endfunction

    // steps is 1 or 2; with revert set a landing on DONE walks back one state.
    function automatic top_state_t colour_advance(input top_state_t s, input int steps,
                                                  input logic revert);
        top_state_t n;
        case (s)
            UNVISITED: n = (steps == 1) ? DONE : INTER;
            INTER:     n = DONE;
            DONE:      n = revert ? ((steps == 1) ? UNVISITED : INTER) : DONE;
            default:   n = UNVISITED;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/cube_face_raster_hit_test.sv
// cube_hit_test: three-stage registered point-in-cube-face evaluator.
// Ports:
//   clk_i, reset_i      : clock, synchronous active-high reset
//   x_i, y_i            : point under test (screen coordinates)
//   xo_i, yo_i          : cube top-vertex position
//   top_o/left_o/right_o: one-hot face hit (or all zero), 3 cycles after x_i/y_i
// Stages: S1 deltas, S2 products and absolute values, S3 compares + priority.
module cube_hit_test
    import cube_pkg::*;
#(
    parameter int HALF_W = 50,
    parameter int HALF_H = 30,
    parameter int DEPTH  = 60
) (
    input  logic          clk_i,
    input  logic          reset_i,
    input  logic [XW-1:0] x_i,
    input  logic [YW-1:0] y_i,
    input  logic [XW-1:0] xo_i,
    input  logic [YW-1:0] yo_i,
    output logic          top_o,
    output logic          left_o,
    output logic          right_o
);

    localparam logic signed [PW-1:0] C_HW = PW'(HALF_W);
    localparam logic signed [PW-1:0] C_HH = PW'(HALF_H);
    localparam logic signed [PW-1:0] C_KT = PW'(HALF_W * HALF_H);
    localparam logic signed [PW-1:0] C_K2 = PW'(2 * HALF_W * HALF_H);
    localparam logic signed [PW-1:0] C_KD = PW'(DEPTH * HALF_W);

    // S1
    logic signed [DW-1:0] dx_d, dy_d, dx_q, dy_q;

    assign dx_d = $signed({{(DW-XW){1'b0}}, x_i}) - $signed({{(DW-XW){1'b0}}, xo_i});
    assign dy_d = $signed({{(DW-YW){1'b0}}, y_i}) - $signed({{(DW-YW){1'b0}}, yo_i});

    // S2
    logic signed [PW-1:0] dx_w, dy_w, dyh_w, adx_w, ady_w;
    logic signed [PW-1:0] top_sum_d, dxh_d, dyw_d;
    logic signed [PW-1:0] top_sum_q, dxh_q, dyw_q;
    logic signed [DW-1:0] dx2_q;

    always_comb begin
        dx_w      = sext_d(dx_q);
        dy_w      = sext_d(dy_q);
        // Top diamond is centred HALF_H below the top vertex.
        dyh_w     = dy_w - C_HH;
        adx_w     = dx_w[PW-1]  ? -dx_w  : dx_w;
        ady_w     = dyh_w[PW-1] ? -dyh_w : dyh_w;
        top_sum_d = adx_w * C_HH + ady_w * C_HW;
        dxh_d     = dx_w * C_HH;
        dyw_d     = dy_w * C_HW;
    end

    // S3
    logic signed [PW-1:0] dxe_w, left_lo_w, right_lo_w;
    logic                 top_ok, left_ok, right_ok;

    always_comb begin
        dxe_w      = sext_d(dx2_q);
        // Left/right faces are bounded by the lower diamond edges, shifted down by DEPTH.
        left_lo_w  = C_K2 + dxh_q;
        right_lo_w = C_K2 - dxh_q;
        top_ok     = (top_sum_q <= C_KT);
        left_ok    = dxe_w[PW-1] && (dxe_w >= -C_HW) &&
                     (dyw_q >= left_lo_w) && (dyw_q <= left_lo_w + C_KD);
        right_ok   = !dxe_w[PW-1] && (dxe_w <= C_HW) &&
                     (dyw_q >= right_lo_w) && (dyw_q <= right_lo_w + C_KD);
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            dx_q      <= '0;
            dy_q      <= '0;
            top_sum_q <= '0;
            dxh_q     <= '0;
            dyw_q     <= '0;
            dx2_q     <= '0;
            top_o     <= 1'b0;
            left_o    <= 1'b0;
            right_o   <= 1'b0;
        end else begin
            dx_q      <= dx_d;
            dy_q      <= dy_d;
            top_sum_q <= top_sum_d;
            dxh_q     <= dxh_d;
            dyw_q     <= dyw_d;
            dx2_q     <= dx_q;
            top_o     <= top_ok;
            left_o    <= !top_ok && left_ok;
            right_o   <= !top_ok && !left_ok && right_ok;
        end
    end

endmodule

// File: rtl/cube_face_raster.sv
// cube_face_raster: per-cube face classifier and landing tracker.
// Ports:
//   clk_i, reset_i            : clock, synchronous active-high reset
//   x_cnt_i, y_cnt_i          : current scan pixel
//   x_offset_i, y_offset_i    : cube top vertex, latched on frame_start_i
//   qbert_x_i, qbert_y_i      : Q*bert foot position, latched on frame_start_i
//   frame_start_i             : one-cycle pulse at start of vertical blank
//   clear_i                   : level restart, colour back to UNVISITED
//   top/left/right_face_o     : face of the pixel presented 3 cycles earlier
//   top_state_o               : colour state (0 UNVISITED, 1 INTER, 2 DONE)
//   qbert_on_o                : Q*bert on this top face, updated once per frame
//   land_pulse_o              : one-cycle pulse on each new landing
//
// Occupancy FSM (updated only on the eval cycle, frame_start + 4):
//   state | meaning
//   OFF   | Q*bert not on this top face; a hit is a new landing
//   ON    | Q*bert standing on this top face; further hits are ignored
module cube_face_raster
    import cube_pkg::*;
#(
    parameter int HALF_W = 50,
    parameter int HALF_H = 30,
    parameter int DEPTH  = 60,
    parameter int STEPS  = 2,
    parameter int REVERT = 0
) (
    input  logic          clk_i,
    input  logic          reset_i,
    input  logic [XW-1:0] x_cnt_i,
    input  logic [YW-1:0] y_cnt_i,
    input  logic [XW-1:0] x_offset_i,
    input  logic [YW-1:0] y_offset_i,
    input  logic [XW-1:0] qbert_x_i,
    input  logic [YW-1:0] qbert_y_i,
    input  logic          frame_start_i,
    input  logic          clear_i,
    output logic          top_face_o,
    output logic          left_face_o,
    output logic          right_face_o,
    output logic [1:0]    top_state_o,
    output logic          qbert_on_o,
    output logic          land_pulse_o
);

    // One latch cycle plus three pipeline stages before the Q*bert hit is usable.
    localparam logic [2:0] EVAL_LOAD = 3'd4;

    logic [XW-1:0] xo_q, qx_q;
    logic [YW-1:0] yo_q, qy_q;
    logic [2:0]    eval_cnt_q, eval_cnt_d;
    logic          eval_now;
    logic          q_top;

    top_state_t    top_state_q;
    occ_state_t    occ_q;
    logic          qbert_on_q;
    logic          land_pulse_q;

    cube_hit_test #(.HALF_W(HALF_W), .HALF_H(HALF_H), .DEPTH(DEPTH)) u_pix_hit (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .x_i     (x_cnt_i),
        .y_i     (y_cnt_i),
        .xo_i    (xo_q),
        .yo_i    (yo_q),
        .top_o   (top_face_o),
        .left_o  (left_face_o),
        .right_o (right_face_o)
    );

    // Only the top-face result matters for landings.
    cube_hit_test #(.HALF_W(HALF_W), .HALF_H(HALF_H), .DEPTH(DEPTH)) u_qbert_hit (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .x_i     (qx_q),
        .y_i     (qy_q),
        .xo_i    (xo_q),
        .yo_i    (yo_q),
        .top_o   (q_top),
        .left_o  (),
        .right_o ()
    );

    // A new frame_start reloads the timer, so an in-flight eval is dropped.
    always_comb begin
        eval_cnt_d = eval_cnt_q;
        if (frame_start_i) begin
            eval_cnt_d = EVAL_LOAD;
        end else if (eval_cnt_q != 3'd0) begin
            eval_cnt_d = eval_cnt_q - 3'd1;
        end
    end

    assign eval_now = (eval_cnt_q == 3'd1) && !frame_start_i;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            xo_q         <= '0;
            yo_q         <= '0;
            qx_q         <= '0;
            qy_q         <= '0;
            eval_cnt_q   <= '0;
            top_state_q  <= UNVISITED;
            occ_q        <= OFF;
            qbert_on_q   <= 1'b0;
            land_pulse_q <= 1'b0;
        end else begin
            land_pulse_q <= 1'b0;
            eval_cnt_q   <= eval_cnt_d;
            if (frame_start_i) begin
                xo_q <= x_offset_i;
                yo_q <= y_offset_i;
                qx_q <= qbert_x_i;
                qy_q <= qbert_y_i;
            end
            if (clear_i) begin
                top_state_q <= UNVISITED;
                occ_q       <= OFF;
                qbert_on_q  <= 1'b0;
            end else if (eval_now) begin
                qbert_on_q <= q_top;
                case (occ_q)
                    OFF: begin
                        if (q_top) begin
                            occ_q        <= ON;
                            land_pulse_q <= 1'b1;
                            top_state_q  <= colour_advance(top_state_q, STEPS, REVERT != 0);
                        end
                    end
                    ON: begin
                        if (!q_top) begin
                            occ_q <= OFF;
                        end
                    end
                    default: occ_q <= OFF;
                endcase
            end else if (!(top_state_q inside {UNVISITED, INTER, DONE})) begin
                top_state_q <= UNVISITED;
            end
        end
    end

    assign top_state_o  = top_state_q;
    assign qbert_on_o   = qbert_on_q;
    assign land_pulse_o = land_pulse_q;

endmodule

// File: tb/tb_cube_face_raster.sv
// Directed bench for cube_face_raster. Three instances share stimulus:
//   dut0 STEPS=2 REVERT=0, dut1 STEPS=2 REVERT=1, dut2 STEPS=1 REVERT=1.
// Geometry HALF_W=50, HALF_H=30, DEPTH=60, cube vertex at (400,200).
module tb_cube_face_raster;

    localparam logic [10:0] IDLE_X = 11'd0;
    localparam logic [9:0]  IDLE_Y = 10'd1000;

    logic        clk = 1'b0;
    logic        reset;
    logic [10:0] x_cnt, x_offset, qbert_x;
    logic [9:0]  y_cnt, y_offset, qbert_y;
    logic        frame_start, clear;

    logic        top_f [3];
    logic        left_f [3];
    logic        right_f [3];
    logic [1:0]  st [3];
    logic        on_f [3];
    logic        land [3];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    cube_face_raster #(.HALF_W(50), .HALF_H(30), .DEPTH(60), .STEPS(2), .REVERT(0)) u_dut0 (
        .clk_i(clk), .reset_i(reset), .x_cnt_i(x_cnt), .y_cnt_i(y_cnt),
        .x_offset_i(x_offset), .y_offset_i(y_offset), .qbert_x_i(qbert_x), .qbert_y_i(qbert_y),
        .frame_start_i(frame_start), .clear_i(clear),
        .top_face_o(top_f[0]), .left_face_o(left_f[0]), .right_face_o(right_f[0]),
        .top_state_o(st[0]), .qbert_on_o(on_f[0]), .land_pulse_o(land[0]));

    cube_face_raster #(.HALF_W(50), .HALF_H(30), .DEPTH(60), .STEPS(2), .REVERT(1)) u_dut1 (
        .clk_i(clk), .reset_i(reset), .x_cnt_i(x_cnt), .y_cnt_i(y_cnt),
        .x_offset_i(x_offset), .y_offset_i(y_offset), .qbert_x_i(qbert_x), .qbert_y_i(qbert_y),
        .frame_start_i(frame_start), .clear_i(clear),
        .top_face_o(top_f[1]), .left_face_o(left_f[1]), .right_face_o(right_f[1]),
        .top_state_o(st[1]), .qbert_on_o(on_f[1]), .land_pulse_o(land[1]));

    cube_face_raster #(.HALF_W(50), .HALF_H(30), .DEPTH(60), .STEPS(1), .REVERT(1)) u_dut2 (
        .clk_i(clk), .reset_i(reset), .x_cnt_i(x_cnt), .y_cnt_i(y_cnt),
        .x_offset_i(x_offset), .y_offset_i(y_offset), .qbert_x_i(qbert_x), .qbert_y_i(qbert_y),
        .frame_start_i(frame_start), .clear_i(clear),
        .top_face_o(top_f[2]), .left_face_o(left_f[2]), .right_face_o(right_f[2]),
        .top_state_o(st[2]), .qbert_on_o(on_f[2]), .land_pulse_o(land[2]));

    function automatic logic [2:0] faces0();
        return {top_f[0], left_f[0], right_f[0]};
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Inputs change just after a negedge; outputs are read at negedges.
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Single pixel, idle before and after: checks the exact 3-cycle latency.
    task automatic pix(input string tag, input logic [10:0] x, input logic [9:0] y,
                       input logic [2:0] exp);
        x_cnt = x; y_cnt = y;
        tick(1);
        x_cnt = IDLE_X; y_cnt = IDLE_Y;
        tick(1);
        check_eq({tag, "_pre"}, 32'(faces0()), 32'd0);
        tick(1);
        check_eq(tag, 32'(faces0()), 32'(exp));
        tick(1);
        check_eq({tag, "_post"}, 32'(faces0()), 32'd0);
    endtask

    // One frame with Q*bert at (qx,qy); result lands at frame_start + 4.
    task automatic frame_eval(input string tag, input logic [10:0] qx, input logic [9:0] qy,
                              input logic p, input logic on,
                              input logic [1:0] s0, input logic [1:0] s1, input logic [1:0] s2);
        qbert_x = qx; qbert_y = qy; frame_start = 1'b1;
        tick(1);
        frame_start = 1'b0;
        tick(3);
        check_eq({tag, "_pulse_early"}, 32'(land[0]), 32'd0);
        tick(1);
        check_eq({tag, "_pulse0"}, 32'(land[0]), 32'(p));
        check_eq({tag, "_pulse1"}, 32'(land[1]), 32'(p));
        check_eq({tag, "_pulse2"}, 32'(land[2]), 32'(p));
        check_eq({tag, "_on0"},    32'(on_f[0]), 32'(on));
        check_eq({tag, "_st0"},    32'(st[0]),   32'(s0));
        check_eq({tag, "_st1"},    32'(st[1]),   32'(s1));
        check_eq({tag, "_st2"},    32'(st[2]),   32'(s2));
        tick(1);
        check_eq({tag, "_pulse_width"}, 32'(land[0]), 32'd0);
    endtask

    initial begin
        reset = 1'b1; clear = 1'b0; frame_start = 1'b0;
        x_cnt = IDLE_X; y_cnt = IDLE_Y;
        x_offset = 11'd400; y_offset = 10'd200;
        qbert_x = 11'd100; qbert_y = 10'd100;
        tick(2);
        check_eq("rst_faces", 32'(faces0()), 32'd0);
        check_eq("rst_state", 32'(st[0]), 32'd0);
        check_eq("rst_on",    32'(on_f[0]), 32'd0);
        check_eq("rst_pulse", 32'(land[0]), 32'd0);
        reset = 1'b0;

        frame_eval("f0", 11'd100, 10'd100, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0);

        pix("top",   11'd400, 10'd230, 3'b100);
        pix("left",  11'd380, 10'd270, 3'b010);
        pix("right", 11'd430, 10'd280, 3'b001);
        pix("above", 11'd400, 10'd199, 3'b000);

        // Back-to-back pixels, one per cycle.
        x_cnt = 11'd400; y_cnt = 10'd230; tick(1);
        x_cnt = 11'd380; y_cnt = 10'd270; tick(1);
        x_cnt = 11'd430; y_cnt = 10'd280; tick(1);
        x_cnt = IDLE_X;  y_cnt = IDLE_Y;
        check_eq("burst0", 32'(faces0()), 32'b100);
        tick(1); check_eq("burst1", 32'(faces0()), 32'b010);
        tick(1); check_eq("burst2", 32'(faces0()), 32'b001);
        tick(1); check_eq("burst3", 32'(faces0()), 32'b000);

        // Offset only takes effect at frame_start.
        x_offset = 11'd500;
        pix("xo_held", 11'd400, 10'd230, 3'b100);
        frame_eval("f_xo", 11'd100, 10'd100, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0);
        pix("xo_old", 11'd400, 10'd230, 3'b000);
        pix("xo_new", 11'd500, 10'd230, 3'b100);
        x_offset = 11'd400;
        frame_eval("f_xo_back", 11'd100, 10'd100, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0);

        // Landings.
        frame_eval("f1", 11'd400, 10'd230, 1'b1, 1'b1, 2'd1, 2'd1, 2'd2);
        frame_eval("f2", 11'd400, 10'd230, 1'b0, 1'b1, 2'd1, 2'd1, 2'd2);
        frame_eval("f3", 11'd400, 10'd230, 1'b0, 1'b1, 2'd1, 2'd1, 2'd2);
        frame_eval("f4", 11'd400, 10'd230, 1'b0, 1'b1, 2'd1, 2'd1, 2'd2);
        frame_eval("f5", 11'd100, 10'd100, 1'b0, 1'b0, 2'd1, 2'd1, 2'd2);
        frame_eval("f6", 11'd400, 10'd230, 1'b1, 1'b1, 2'd2, 2'd2, 2'd0);
        frame_eval("f7", 11'd100, 10'd100, 1'b0, 1'b0, 2'd2, 2'd2, 2'd0);
        frame_eval("f8", 11'd400, 10'd230, 1'b1, 1'b1, 2'd2, 2'd1, 2'd2);
        frame_eval("f9", 11'd100, 10'd100, 1'b0, 1'b0, 2'd2, 2'd1, 2'd2);

        // clear on the eval cycle of a landing.
        qbert_x = 11'd400; qbert_y = 10'd230; frame_start = 1'b1;
        tick(1);
        frame_start = 1'b0;
        tick(3);
        clear = 1'b1;
        tick(1);
        clear = 1'b0;
        check_eq("clr_pulse0", 32'(land[0]), 32'd0);
        check_eq("clr_pulse1", 32'(land[1]), 32'd0);
        check_eq("clr_st0",    32'(st[0]),   32'd0);
        check_eq("clr_st1",    32'(st[1]),   32'd0);
        check_eq("clr_st2",    32'(st[2]),   32'd0);
        check_eq("clr_on0",    32'(on_f[0]), 32'd0);
        tick(2);

        frame_eval("f11", 11'd400, 10'd230, 1'b1, 1'b1, 2'd1, 2'd1, 2'd2);

        // frame_start two cycles into an eval restarts it; the stale miss is dropped.
        qbert_x = 11'd100; qbert_y = 10'd100; frame_start = 1'b1;
        tick(1);
        frame_start = 1'b0;
        tick(1);
        qbert_x = 11'd400; qbert_y = 10'd230; frame_start = 1'b1;
        tick(1);
        frame_start = 1'b0;
        tick(2);
        check_eq("rs_stale_on",    32'(on_f[0]), 32'd1);
        check_eq("rs_stale_pulse", 32'(land[0]), 32'd0);
        tick(2);
        check_eq("rs_on",    32'(on_f[0]), 32'd1);
        check_eq("rs_pulse", 32'(land[0]), 32'd0);
        check_eq("rs_st0",   32'(st[0]),   32'd1);
        tick(2);

        frame_eval("f13", 11'd100, 10'd100, 1'b0, 1'b0, 2'd1, 2'd1, 2'd2);
        frame_eval("f14", 11'd400, 10'd230, 1'b1, 1'b1, 2'd2, 2'd2, 2'd0);

        // Reset mid-frame with DONE state and a face on screen.
        qbert_x = 11'd100; qbert_y = 10'd100;
        x_cnt = 11'd400; y_cnt = 10'd230;
        tick(3);
        check_eq("prerst_face",  32'(faces0()), 32'b100);
        check_eq("prerst_state", 32'(st[0]), 32'd2);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        check_eq("mrst_faces", 32'(faces0()), 32'd0);
        check_eq("mrst_state", 32'(st[0]), 32'd0);
        check_eq("mrst_on",    32'(on_f[0]), 32'd0);
        check_eq("mrst_pulse", 32'(land[0]), 32'd0);
        tick(4);
        check_eq("mrst_noface", 32'(faces0()), 32'd0);
        frame_start = 1'b1;
        tick(1);
        frame_start = 1'b0;
        tick(2);
        check_eq("mrst_face_wait", 32'(faces0()), 32'd0);
        tick(1);
        check_eq("mrst_face_back", 32'(faces0()), 32'b100);
        tick(3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
